// File: rtl/l2_pkg.sv
// Shared definitions for the L2 tree pseudo-LRU engine: default geometry, tree
// types and the tree touch function used by l2_tree_plru.
package l2_pkg;

  // Default associativity and derived widths
  localparam int unsigned PLRU_DEF_WAYS  = 8;
  localparam int unsigned PLRU_DEF_WAY_W = $clog2(PLRU_DEF_WAYS);
  localparam int unsigned PLRU_DEF_NODES = PLRU_DEF_WAYS - 1;

  // Widest supported geometry (32 ways). The wide tree keeps one spare bit so a
  // caller of any associativity always has at least one unused upper bit.
  localparam int unsigned PLRU_MAX_WAY_W = 5;
  localparam int unsigned PLRU_WIDE_BITS = 32;

  typedef logic [PLRU_DEF_WAYS-2:0]  plru_tree_t;
  typedef logic [PLRU_WIDE_BITS-1:0] plru_tree_wide_t;
  typedef logic [PLRU_MAX_WAY_W-1:0] plru_way_wide_t;

  // Walk the heap-ordered path to 'way' (MSB selects at the root) and point
  // every node on it away from 'way'. Nodes off the path are untouched.
  function automatic plru_tree_wide_t plru_touch(plru_tree_wide_t tree, plru_way_wide_t way,
                                                 int unsigned way_w);
    plru_tree_wide_t t;
    int              node;
    logic            b;
    t    = tree;
    node = 0;
    for (int l = PLRU_MAX_WAY_W - 1; l >= 0; l--) begin
      if (l < int'(way_w)) begin
        b = way[l];
        for (int n = 0; n < PLRU_WIDE_BITS; n++) begin
          if (n == node) t[n] = ~b;
        end
        node = 2 * node + 1 + int'(b);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/l2_tree_plru_if.sv
// Controller-side bus of the L2 tree PLRU engine. way_disable exists only when
// L2_PLRU_WAY_DISABLE_EN is defined.
interface l2_tree_plru_if #(
  parameter int unsigned NUM_WAYS = 8,
  parameter int unsigned S_INDEX  = 4
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);

  logic                touch_valid;
  logic [S_INDEX-1:0]  touch_set;
  logic [WAY_W-1:0]    touch_way;
  logic                victim_req;
  logic [S_INDEX-1:0]  victim_set;
  logic [NUM_WAYS-1:0] valid_mask;
  logic                victim_valid;
  logic [WAY_W-1:0]    victim_way;
`ifdef L2_PLRU_WAY_DISABLE_EN
  logic [NUM_WAYS-1:0] way_disable;
`endif

  modport master (
    output touch_valid, touch_set, touch_way, victim_req, victim_set, valid_mask,
`ifdef L2_PLRU_WAY_DISABLE_EN
    output way_disable,
`endif
    input  victim_valid, victim_way
  );

  modport slave (
    input  touch_valid, touch_set, touch_way, victim_req, victim_set, valid_mask,
`ifdef L2_PLRU_WAY_DISABLE_EN
    input  way_disable,
`endif
    output victim_valid, victim_way
  );

endinterface

// File: rtl/l2_plru_victim_sel.sv
// Combinational victim picker for one PLRU tree: lowest invalid way first,
// otherwise a root-to-leaf walk. With L2_PLRU_WAY_DISABLE_EN the walk and the
// invalid search skip disabled ways (an all-disabled mask is ignored).
module l2_plru_victim_sel #(
  parameter  int unsigned NUM_WAYS = 8,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] tree_i,
  input  logic [NUM_WAYS-1:0] valid_mask_i,
`ifdef L2_PLRU_WAY_DISABLE_EN
  input  logic [NUM_WAYS-1:0] way_disable_i,
`endif
  output logic [WAY_W-1:0]    way_o
);

  // Invalid-first search, then tree walk steering around disabled subtrees
  always_comb begin
    logic [NUM_WAYS-1:0] dis;
    logic [NUM_WAYS-1:0] invalid;
    logic                found;
    logic                go_right;
    logic                node_bit;
    logic                left_dis;
    logic                right_dis;
    int                  node;
    int                  prefix;

    dis       = '0;
`ifdef L2_PLRU_WAY_DISABLE_EN
    if (!(&way_disable_i)) dis = way_disable_i;
`endif
    invalid   = ~valid_mask_i & ~dis;
    found     = 1'b0;
    go_right  = 1'b0;
    node_bit  = 1'b0;
    left_dis  = 1'b0;
    right_dis = 1'b0;
    node      = 0;
    prefix    = 0;
    way_o     = '0;

    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && invalid[w]) begin
        found = 1'b1;
        way_o = WAY_W'(w);
      end
    end

    if (!found) begin
      for (int d = 0; d < WAY_W; d++) begin
        // A child subtree is "dead" only if every way under it is disabled
        left_dis  = 1'b1;
        right_dis = 1'b1;
        for (int w = 0; w < NUM_WAYS; w++) begin
          if ((w >> (WAY_W - 1 - d)) == 2 * prefix)     left_dis  = left_dis & dis[w];
          if ((w >> (WAY_W - 1 - d)) == 2 * prefix + 1) right_dis = right_dis & dis[w];
        end
        for (int n = 0; n < NUM_WAYS - 1; n++) begin
          if (n == node) node_bit = tree_i[n];
        end
        go_right = node_bit;
        if (go_right && right_dis)       go_right = 1'b0;
        else if (!go_right && left_dis)  go_right = 1'b1;
        prefix = 2 * prefix + int'(go_right);
        node   = 2 * node + 1 + int'(go_right);
      end
      way_o = WAY_W'(prefix);
    end
  end

endmodule

// File: rtl/l2_tree_plru.sv
// L2 tree pseudo-LRU engine: one (NUM_WAYS-1)-bit tree per set, updated on
// every touch, with a registered victim one cycle after each request.
// Optional feature: L2_PLRU_WAY_DISABLE_EN adds a per-way replacement disable.
module l2_tree_plru
  import l2_pkg::*;
#(
  parameter int unsigned NUM_WAYS = PLRU_DEF_WAYS,
  parameter int unsigned S_INDEX  = 4
) (
  input logic           clk,
  input logic           rst,
  l2_tree_plru_if.slave bus
);

  localparam int unsigned WAY_W    = $clog2(NUM_WAYS);
  localparam int unsigned NUM_SETS = 2 ** S_INDEX;
  localparam int unsigned NODES    = NUM_WAYS - 1;

  logic [NODES-1:0] tree_q [NUM_SETS];
  logic [NODES-1:0] tree_d [NUM_SETS];
  plru_tree_wide_t  touch_wide;
  logic             unused_touch_hi;
  logic [WAY_W-1:0] sel_way;
  logic             victim_valid_q, victim_valid_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;

  // Tree next state: only the touched set changes
  always_comb begin
    tree_d     = tree_q;
    touch_wide = plru_touch(plru_tree_wide_t'(tree_q[bus.touch_set]),
                            plru_way_wide_t'(bus.touch_way), WAY_W);
    if (bus.touch_valid) tree_d[bus.touch_set] = touch_wide[NODES-1:0];
  end

  assign unused_touch_hi = ^touch_wide[PLRU_WIDE_BITS-1:NODES];

  // Victim is taken from the pre-touch tree; no same-cycle bypass
  l2_plru_victim_sel #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_sel (
    .tree_i        (tree_q[bus.victim_set]),
    .valid_mask_i  (bus.valid_mask),
`ifdef L2_PLRU_WAY_DISABLE_EN
    .way_disable_i (bus.way_disable),
`endif
    .way_o         (sel_way)
  );

  // Victim output next state: pulse valid, hold way until the next request
  always_comb begin
    victim_valid_d = bus.victim_req;
    victim_way_d   = victim_way_q;
    if (bus.victim_req) victim_way_d = sel_way;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) tree_q[i] <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      tree_q         <= tree_d;
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way   = victim_way_q;

endmodule

// File: tb/tb_l2_tree_plru.sv
// Bench for l2_tree_plru: a 4-way and an 8-way instance driven with directed
// vectors; expected victims are queued at request time and checked by monitors.
module tb_l2_tree_plru;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_tree_plru_if #(.NUM_WAYS(4), .S_INDEX(4)) if4 ();
  l2_tree_plru_if #(.NUM_WAYS(8), .S_INDEX(4)) if8 ();

  l2_tree_plru #(.NUM_WAYS(4), .S_INDEX(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  l2_tree_plru #(.NUM_WAYS(8), .S_INDEX(4)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  typedef struct {
    string name;
    int    way;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a victim
  always @(negedge clk) begin
    if (if4.victim_valid === 1'b1) begin
      if (q4.size() == 0) check("v4_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        check(e.name, int'(if4.victim_way), e.way);
      end
    end
    if (if8.victim_valid === 1'b1) begin
      if (q8.size() == 0) check("v8_unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = q8.pop_front();
        check(e.name, int'(if8.victim_way), e.way);
      end
    end
  end

  task automatic idle();
    if4.touch_valid = 1'b0;  if4.victim_req = 1'b0;
    if8.touch_valid = 1'b0;  if8.victim_req = 1'b0;
  endtask

  task automatic init();
    idle();
    if4.touch_set = '0;  if4.touch_way = '0;  if4.victim_set = '0;  if4.valid_mask = '1;
    if8.touch_set = '0;  if8.touch_way = '0;  if8.victim_set = '0;  if8.valid_mask = '1;
`ifdef L2_PLRU_WAY_DISABLE_EN
    if4.way_disable = '0;
    if8.way_disable = '0;
`endif
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic touch4(int set, int way);
    if4.touch_valid = 1'b1;  if4.touch_set = 4'(set);  if4.touch_way = 2'(way);
  endtask

  task automatic touch8(int set, int way);
    if8.touch_valid = 1'b1;  if8.touch_set = 4'(set);  if8.touch_way = 3'(way);
  endtask

  task automatic req4(string name, int set, logic [3:0] mask, int exp);
    if4.victim_req = 1'b1;  if4.victim_set = 4'(set);  if4.valid_mask = mask;
    q4.push_back('{name: name, way: exp});
  endtask

  task automatic req8(string name, int set, logic [7:0] mask, int exp);
    if8.victim_req = 1'b1;  if8.victim_set = 4'(set);  if8.valid_mask = mask;
    q8.push_back('{name: name, way: exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init();
    #2 rst = 1'b1;
    #1;
    check("rst_v4_valid", int'(if4.victim_valid), 0);
    check("rst_v4_way",   int'(if4.victim_way),   0);
    check("rst_v8_valid", int'(if8.victim_valid), 0);
    check("rst_v8_way",   int'(if8.victim_way),   0);
    @(negedge clk);
    rst = 1'b0;

    // 4-way: reset tree, then touch sequence on set 3
    req4("r4_reset_set0", 0, 4'hf, 0);           step();
    touch4(3, 0);                                 step();
    req4("r4_after_t0", 3, 4'hf, 2);              step();
    touch4(3, 2);                                 step();
    check("r4_hold_valid", int'(if4.victim_valid), 0);
    check("r4_hold_way",   int'(if4.victim_way),   2);
    req4("r4_after_t2", 3, 4'hf, 1);              step();

    // 8-way: touch all ways in order on set 5, untouched set 6
    for (int w = 0; w < 8; w++) begin
      touch8(5, w);                               step();
    end
    req8("r8_set5_seq", 5, 8'hff, 0);             step();
    req8("r8_set6_fresh", 6, 8'hff, 0);           step();
    req8("r8_invalid4", 7, 8'b1110_1111, 4);      step();

    // Same-cycle touch and request: pre-touch tree, then updated tree
    touch8(2, 0);
    req8("r8_same_cycle", 2, 8'hff, 0);           step();
    req8("r8_post_touch", 2, 8'hff, 4);           step();

    // Touch 0 then 4 on set 1; back-to-back requests on both instances
    touch8(1, 0);                                 step();
    touch8(1, 4);                                 step();
    req8("r8_set1", 1, 8'hff, 2);
    req4("r4_invalid3", 3, 4'b0111, 3);           step();
    req8("r8_multi_invalid", 1, 8'b1010_0101, 1);
    touch4(4, 0);
    req4("r4_other_set", 5, 4'hf, 0);             step();

`ifdef L2_PLRU_WAY_DISABLE_EN
    if4.way_disable = 4'b0011;
    req4("r4_dis0011", 9, 4'hf, 2);               step();
    if4.way_disable = 4'b1111;
    req4("r4_dis_all", 9, 4'hf, 0);               step();
    if4.way_disable = 4'b0001;
    req4("r4_dis_invalid0", 9, 4'b1110, 1);       step();
    if4.way_disable = 4'b0000;
`endif

    step();
    step();

    // Reset while a result is in flight: valid must drop at once
    if4.victim_req = 1'b1;  if4.victim_set = 4'd3;  if4.valid_mask = 4'hf;
    @(posedge clk);
    #1;
    check("rst_pre_valid", int'(if4.victim_valid), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", int'(if4.victim_valid), 0);
    check("rst_mid_way",   int'(if4.victim_way),   0);
    if4.victim_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req4("r4_post_reset", 3, 4'hf, 0);            step();

    repeat (3) step();
    check("q4_drained", q4.size(), 0);
    check("q8_drained", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
